// File: rtl/seq_serializer.sv
// Parallel-to-serial frame shifter, MSB first, feeding the sequence detector.
// Optional even-parity trailer bit when SEQ_SER_PARITY_EN is defined.
module seq_serializer #(
    parameter int DATA_WIDTH = 9,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [LEN_WIDTH-1:0]  din_len,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic                  seq_out,
    output logic                  seq_vld,
    output logic                  done
);

`ifdef SEQ_SER_PARITY_EN
    localparam int PW = 1;
`else
    localparam int PW = 0;
`endif
    localparam int SW = DATA_WIDTH + PW;
    localparam int CW = $clog2(SW + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_nx_state;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_nx_cnt;
    logic [CW-1:0]   w_len;
    logic [CW-1:0]   w_load_cnt;
    logic [SW-1:0]   r_shift;
    logic [SW-1:0]   w_nx_shift;
    logic [SW-1:0]   w_frame;
    logic [SW-1:0]   w_load;
    logic            r_done;
    logic            w_nx_done;
    logic            w_last;
    logic            w_ready;
    logic            w_accept;
    logic            w_nonzero;

    always_comb begin
        if (din_len > LEN_WIDTH'(DATA_WIDTH)) begin
            w_len = CW'(DATA_WIDTH);
        end else begin
            w_len = CW'(din_len);
        end
    end

`ifdef SEQ_SER_PARITY_EN
    logic [DATA_WIDTH-1:0] w_mask;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_mask[i] = (i < int'(w_len));
        end
    end

    assign w_frame = {din, ^(din & w_mask)};
`else
    assign w_frame = din;
`endif

    // Left-align the frame so its first bit sits at the shifter MSB;
    // bits above din_len-1 fall off the top.
    assign w_load     = w_frame << (CW'(DATA_WIDTH) - w_len);
    assign w_load_cnt = w_len + CW'(PW);
    assign w_nonzero  = (w_len != '0);

    assign w_last    = (r_cnt == CW'(1));
    assign w_ready   = ~rst & ((r_state == IDLE) | w_last);
    assign w_accept  = din_valid & w_ready;
    assign din_ready = w_ready;

    always_comb begin
        w_nx_state = r_state;
        w_nx_cnt   = r_cnt;
        w_nx_shift = r_shift << 1;
        unique case (r_state)
            IDLE: begin
                if (w_accept && w_nonzero) begin
                    w_nx_state = SHIFT;
                    w_nx_cnt   = w_load_cnt;
                    w_nx_shift = w_load;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    if (w_accept && w_nonzero) begin
                        w_nx_cnt   = w_load_cnt;
                        w_nx_shift = w_load;
                    end else begin
                        w_nx_state = IDLE;
                        w_nx_cnt   = '0;
                        w_nx_shift = '0;
                    end
                end else begin
                    w_nx_cnt = r_cnt - CW'(1);
                end
            end
            default: begin
                w_nx_state = IDLE;
                w_nx_cnt   = '0;
                w_nx_shift = '0;
            end
        endcase
        w_nx_done = (w_nx_state == SHIFT) && (w_nx_cnt == CW'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nx_state;
            r_cnt   <= w_nx_cnt;
            r_shift <= w_nx_shift;
            r_done  <= w_nx_done;
        end
    end

    // Shifter is zero whenever no frame is in flight, so its MSB is 0 then.
    assign seq_out = r_shift[SW-1];
    assign seq_vld = (r_state == SHIFT);
    assign done    = r_done;

endmodule

// File: doc/seq_serializer.md
SEQ_SERIALIZER -- requirements
Module: seq_serializer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 9, maximum frame length in bits (range 2..32).
REQ-002 The block SHALL have parameter LEN_WIDTH, default 4, width of din_len; it SHALL be wide enough to hold DATA_WIDTH.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 din  input  DATA_WIDTH  parallel frame; the frame bits are din[din_len-1:0], sent MSB first.
REQ-006 din_len  input  LEN_WIDTH  number of bits to send from din.
REQ-007 din_valid  input  1  din and din_len are valid.
REQ-008 din_ready  output  1  block accepts a frame on the current rising edge.
REQ-009 seq_out  output  1  serial bit stream; this port feeds the sequence detector's serial input.
REQ-010 seq_vld  output  1  seq_out carries a frame bit this cycle.
REQ-011 done  output  1  one-cycle pulse coincident with the final serial bit of a frame.

Function
REQ-012 A frame SHALL be accepted on a rising edge where din_valid=1 and din_ready=1; din and din_len are sampled at that edge.
REQ-013 The FSM SHALL have two states, IDLE and SHIFT; reset SHALL enter IDLE.
REQ-014 IDLE -> SHIFT SHALL occur on acceptance with effective length >= 1.
REQ-015 SHIFT -> IDLE SHALL occur on the edge ending the final bit cycle when no new frame is accepted on that edge.
REQ-016 SHIFT -> SHIFT with reload SHALL occur when a new frame is accepted on that same edge.
REQ-017 The effective length SHALL be din_len clamped to DATA_WIDTH; din_len > DATA_WIDTH sends exactly DATA_WIDTH bits.
REQ-018 din_len=0 SHALL be accepted and discarded: no seq_vld, no done, and the state stays or goes to IDLE.
REQ-019 Latency: the first bit, din[len-1], SHALL appear on seq_out with seq_vld=1 in the cycle immediately after the accepting edge.
REQ-020 Each later edge SHALL advance one bit, ending with din[0], so an N-bit frame occupies exactly N consecutive seq_vld cycles.
REQ-021 din_ready SHALL be 1 in IDLE and in the final bit cycle of SHIFT, and 0 otherwise.
REQ-022 Because of REQ-021, a frame accepted in the final bit cycle SHALL start its first bit in the very next cycle, with no seq_vld gap.
REQ-023 When seq_vld=0, seq_out SHALL be 0.
REQ-024 done SHALL be 1 only during the final bit cycle of each frame, including single-bit frames.
REQ-025 All outputs except din_ready SHALL be driven from registers.
REQ-026 din_ready SHALL be derived combinationally from state and the bit counter only, with no path from din_valid.
REQ-027 The bit counter SHALL count down from the effective length to 1.
REQ-028 The bit counter SHALL never wrap; it is reloaded only on acceptance.

Reset
REQ-029 While rst=1, the block SHALL hold seq_out=0, seq_vld=0, done=0, din_ready=0, state=IDLE and counter=0.
REQ-030 An assertion of rst mid-frame SHALL abort the frame immediately (asynchronously); the remaining bits SHALL be lost and done SHALL NOT pulse.
REQ-031 After rst deasserts, din_ready SHALL be 1 in the first cycle.

Configuration
REQ-032 The configurable feature SHALL be controlled by macro SEQ_SER_PARITY_EN.
REQ-033 With SEQ_SER_PARITY_EN defined, one even-parity bit (XOR of the N frame bits) SHALL follow din[0], making the frame N+1 seq_vld cycles.
REQ-034 With SEQ_SER_PARITY_EN defined, done and the din_ready window SHALL move to the parity-bit cycle.
REQ-035 With SEQ_SER_PARITY_EN defined, frames with din_len=0 SHALL still be discarded with no parity bit.
REQ-036 Without SEQ_SER_PARITY_EN, no parity bit SHALL be sent and no parity logic SHALL be present.

Verification
REQ-037 din=9'b101011011, din_len=9, single accept -> seq_out over 9 consecutive seq_vld cycles SHALL be 1,0,1,0,1,1,0,1,1; done SHALL be 1 only in cycle 9; din_ready SHALL be 1 in cycle 9 and then in IDLE.
REQ-038 Back-to-back frames 3'b101 then 2'b11 with din_valid held high -> seq_vld SHALL be 1 for 5 consecutive cycles, seq_out 1,0,1,1,1, and done SHALL pulse in cycles 3 and 5.
REQ-039 din_len=0 accepted, then din_len=15 with din=9'h1FF -> the first frame SHALL produce no output; the second SHALL produce exactly 9 ones with done on the 9th.
REQ-040 rst asserted during bit 4 of a 9-bit frame -> seq_vld, seq_out and din_ready SHALL go to 0 without waiting for a clock edge; no done pulse; after release, a new 2-bit frame 2'b10 SHALL send 1,0.
REQ-041 With SEQ_SER_PARITY_EN defined, din=3'b110, din_len=3 -> seq_out SHALL be 1,1,0,0 over 4 cycles, with done in cycle 4.
REQ-042 Single-bit frame din[0]=1, din_len=1 -> 1 seq_vld cycle with seq_out=1 and done=1 in the same cycle.
